// File: rtl/iob_cfg_ctrl_if.sv
// Host-side and scan-chain signals of the IO-column configuration controller.
// master = host / fabric config port, slave = the controller.
interface iob_cfg_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic              WR_VALID;
   logic              WR_READY;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [2:0]        WR_DATA;
   logic              COMMIT;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [2:0]        RD_DATA;
   logic              BUSY;
   logic              DONE;
   logic              ERR;
   logic              SDO;
   logic              SEN;
   logic              LATCH;

   modport master (
      output WR_VALID, WR_ADDR, WR_DATA, COMMIT, RD_ADDR,
      input  WR_READY, RD_DATA, BUSY, DONE, ERR, SDO, SEN, LATCH
   );

   modport slave (
      input  WR_VALID, WR_ADDR, WR_DATA, COMMIT, RD_ADDR,
      output WR_READY, RD_DATA, BUSY, DONE, ERR, SDO, SEN, LATCH
   );
endinterface

// File: rtl/iob_cfg_ctrl.sv
// IO-column config controller: shadow array of {TSMUX,DORREG} per IO block,
// serialized MSB-block-first onto the config scan chain on COMMIT, then LATCH.
module iob_cfg_ctrl #(
   parameter int NUM_IOB = 14,
   parameter int ADDR_W  = 4
) (
   input logic           IOCLK,
   input logic           RST,
   iob_cfg_ctrl_if.slave bus
);
   localparam int NBITS = 3 * NUM_IOB;
   localparam int CNT_W = $clog2(NBITS);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NBITS - 1);
   localparam logic [ADDR_W:0]  LP_NUM  = (ADDR_W + 1)'(NUM_IOB);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

   state_t               r_state, w_nxt;
   logic [2:0]           r_shd     [NUM_IOB];
   logic [2:0]           w_shd_nxt [NUM_IOB];
   logic [CNT_W-1:0]     r_cnt, w_cnt_inc;
   logic [2**CNT_W-1:0]  w_ser;
   logic [2:0]           w_rd;
   logic                 w_wr_acc, w_wr_inrng, w_last;
   logic                 r_ready, r_busy, r_done, r_err, r_sdo, r_sen, r_latch;
   logic                 w_ready, w_busy, w_done, w_sdo, w_sen, w_latch;

   assign w_wr_acc   = bus.WR_VALID && r_ready;
   assign w_wr_inrng = {1'b0, bus.WR_ADDR} < LP_NUM;
   assign w_last     = (r_cnt == LP_LAST);
   assign w_cnt_inc  = r_cnt + CNT_W'(1);

   // Shadow as it will be after this edge, so a write landing with COMMIT is shifted out.
   always_comb begin
      for (int i = 0; i < NUM_IOB; i++) begin
         w_shd_nxt[i] = r_shd[i];
         if (w_wr_acc && w_wr_inrng && bus.WR_ADDR == ADDR_W'(i))
            w_shd_nxt[i] = bus.WR_DATA;
      end
   end

   // w_ser[k] is the k-th bit on the chain: IOB[NUM_IOB-1] bit2 first, IOB[0] bit0 last.
   always_comb begin
      w_ser = '0;
      for (int i = 0; i < NUM_IOB; i++)
         for (int b = 0; b < 3; b++)
            w_ser[3*(NUM_IOB-1-i) + (2-b)] = w_shd_nxt[i][b];
   end

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NUM_IOB; i++)
         if (bus.RD_ADDR == ADDR_W'(i)) w_rd = r_shd[i];
   end

   always_ff @(posedge IOCLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.COMMIT) w_nxt = S_SHIFT;
         S_SHIFT: if (w_last)     w_nxt = S_LATCH;
         S_LATCH: w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with r_state.
   always_comb begin
      w_ready = (w_nxt == S_IDLE);
      w_busy  = (w_nxt != S_IDLE);
      w_sen   = (w_nxt == S_SHIFT);
      w_latch = (w_nxt == S_LATCH);
      w_done  = (w_nxt == S_LATCH);
      w_sdo   = 1'b0;
      if (w_nxt == S_SHIFT)
         w_sdo = (r_state == S_IDLE) ? w_ser[0] : w_ser[w_cnt_inc];
   end

   always_ff @(posedge IOCLK) begin
      if (RST) begin
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_sdo   <= 1'b0;
         r_sen   <= 1'b0;
         r_latch <= 1'b0;
      end else begin
         r_ready <= w_ready;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_err   <= w_wr_acc && !w_wr_inrng;
         r_sdo   <= w_sdo;
         r_sen   <= w_sen;
         r_latch <= w_latch;
      end
   end

   always_ff @(posedge IOCLK) begin
      if (RST) begin
         r_cnt <= '0;
         for (int i = 0; i < NUM_IOB; i++) r_shd[i] <= 3'b000;
      end else begin
         r_cnt <= (r_state == S_SHIFT && !w_last) ? w_cnt_inc : '0;
         for (int i = 0; i < NUM_IOB; i++) r_shd[i] <= w_shd_nxt[i];
      end
   end

   assign bus.WR_READY = r_ready;
   assign bus.RD_DATA  = w_rd;
   assign bus.BUSY     = r_busy;
   assign bus.DONE     = r_done;
   assign bus.ERR      = r_err;
   assign bus.SDO      = r_sdo;
   assign bus.SEN      = r_sen;
   assign bus.LATCH    = r_latch;
endmodule
